mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control sequencer for the CPU datapath: a Moore FSM that walks each instruction through fetch, decode, execute, memory and write-back. It drives the PC, instruction register, ALU, register-file and memory enables from the current opcode/funct, and stalls on a single shared instruction/data memory port via a req/ack handshake. It sits beside the register file and memory inside `CPU` and replaces single-cycle combinational decode.

## Interface
- `ICNT_W`, 32, width of retired-instruction counter
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `opcode`  in  6  IR[31:26]
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag, valid in BRANCH
- `mem_ack`  in  1  memory completes access this cycle
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  write (with `mem_req`)
- `iord`  out  1  0 = address from PC, 1 = from ALUOut
- `ir_we`  out  1  load IR
- `pc_we`  out  1  load PC
- `pc_src`  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- `alu_src_a`  out  1  0 = PC, 1 = rs
- `alu_src_b`  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
- `alu_op`  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
- `reg_we`, `reg_dst`, `mem_to_reg`  out  1 each  reg-file write, dest (0 = rt, 1 = rd), source (0 = ALUOut, 1 = MDR)
- `state`  out  4  current state code
- `halted`  out  1  in HALT
- `instret`  out  ICNT_W  retired instruction count

## Operation
- States (codes 0-11): FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP; HALT = 15.
- Every output not listed for a state is 0.
- FETCH: `mem_req`=1, `iord`=0, `alu_src_b`=1, ADD. Waits while `mem_ack`=0. On `mem_ack`: `ir_we`=1, `pc_we`=1, `pc_src`=0; next DECODE.
- DECODE: `alu_src_b`=3, ADD (branch target into ALUOut). Dispatch on `opcode`:
  - 0x00 -> EXEC_R
  - 0x08 -> EXEC_I
  - 0x23/0x2B -> MEM_ADDR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - else HALT
- EXEC_R: `alu_src_a`=1, `alu_src_b`=0; `alu_op` from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT. Any other funct -> HALT (no write). Next WB_R.
- WB_R: `reg_we`=1, `reg_dst`=1 -> FETCH.
- EXEC_I (addi): `alu_src_a`=1, `alu_src_b`=2, ADD -> WB_I.
- WB_I: `reg_we`=1, `reg_dst`=0 -> FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2, ADD. Next is MEM_RD for 0x23, MEM_WR for 0x2B.
- MEM_RD: `mem_req`=1, `iord`=1; holds until `mem_ack`, then MEM_WB.
- MEM_WB: `reg_we`=1, `mem_to_reg`=1, `reg_dst`=0 -> FETCH.
- MEM_WR: `mem_req`=1, `mem_we`=1, `iord`=1; holds until `mem_ack`, then FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, SUB, `pc_src`=1, `pc_we`=`zero` -> FETCH.
- JUMP: `pc_src`=2, `pc_we`=1 -> FETCH.
- HALT: `halted`=1, all enables 0. Only `rst` exits.
- `instret`: +1 on any transition into FETCH from a non-FETCH state. Wraps modulo 2^ICNT_W. Never increments in HALT or on reset exit.

## Timing
- Reset (async, while `rst`=1): state = FETCH, `instret`=0. All outputs take FETCH Moore values except `mem_req`, which is forced 0 while `rst` is high.
- First `mem_req` is in the first cycle after `rst` falls.
- Outputs are a pure function of state plus `mem_ack`/`zero`/funct gating. No registered output lag.
- Minimum cycles with zero-wait memory (`mem_ack` in the cycle of request): R/addi/sw 4, lw 5, beq/j 3. Each wait cycle adds 1.
- `mem_req` is held constant with stable `iord`/`mem_we` until the ack cycle. It drops the cycle after ack.
- `mem_ack` outside FETCH/MEM_RD/MEM_WR is ignored.
- `rst` asserted during a memory wait aborts immediately: `mem_req`=0 asynchronously, no IR/PC/reg write.

## Test plan
- Reset then `add` (opcode 0, funct 0x20), `mem_ack` tied 1 -> states 0,1,2,3,0. `reg_we`=1 only in WB_R with `reg_dst`=1. `instret`=1 after 4 cycles.
- `lw` (0x23), `mem_ack` low 3 cycles in MEM_RD -> MEM_RD held 4 cycles with `mem_req`=1, `iord`=1. MEM_WB asserts `reg_we`+`mem_to_reg`. Total 8 cycles.
- `beq` with `zero`=1 then `zero`=0 -> `pc_we`=1 and `pc_src`=1 in first BRANCH only. 3 cycles each; `instret` +2.
- `sw` (0x2B) -> MEM_WR asserts `mem_we`=1, `mem_req`=1. `reg_we` never asserted.
- Illegal opcode 0x3F, or funct 0x00 with opcode 0 -> HALT, `halted`=1, `state`=15, no further `mem_req`, `instret` frozen. `rst` pulse returns to FETCH with `instret`=0.
- `rst` raised mid-FETCH wait -> `mem_req` falls in the same time step, `ir_we`/`pc_we` stay 0. With ICNT_W=4, retiring 16 `j` instructions wraps `instret` to 0.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl - multi-cycle control sequencer for the CPU datapath.
//
// A Moore FSM walks each instruction through FETCH, DECODE, EXEC, MEM and
// write-back. It drives the datapath enables from the current state, the
// opcode and funct fields. It stalls on one shared instruction/data memory
// port using a req/ack handshake.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   opcode, funct     IR[31:26] and IR[5:0]
//   zero              ALU zero flag, used in BRANCH
//   mem_ack           memory completes the pending access this cycle
//   mem_req, mem_we   memory request and write qualifier
//   iord              memory address select (0 = PC, 1 = ALUOut)
//   ir_we, pc_we      instruction register / PC load enables
//   pc_src            PC source (0 = ALU, 1 = ALUOut, 2 = jump target)
//   alu_src_a         ALU A select (0 = PC, 1 = rs)
//   alu_src_b         ALU B select (0 = rt, 1 = 4, 2 = imm, 3 = imm<<2)
//   alu_op            0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
//   reg_we, reg_dst   reg-file write enable, destination (0 = rt, 1 = rd)
//   mem_to_reg        reg-file write source (0 = ALUOut, 1 = MDR)
//   state             current state code
//   halted            FSM is parked in HALT
//   instret           retired instruction count, wraps modulo 2^ICNT_W
module mc_ctrl #(
  parameter int ICNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic              iord,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_src,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [2:0]        alu_op,
  output logic              reg_we,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic [3:0]        state,
  output logic              halted,
  output logic [ICNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_WB_R     = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_I     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WB   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  // Maps an R-type funct to {legal, alu_op}; illegal codes give {0, ADD}.
  function automatic logic [3:0] decode_funct(input logic [5:0] f);
    logic [3:0] res;
    case (f)
      6'h20:   res = {1'b1, ALU_ADD};
      6'h22:   res = {1'b1, ALU_SUB};
      6'h24:   res = {1'b1, ALU_AND};
      6'h25:   res = {1'b1, ALU_OR};
      6'h2A:   res = {1'b1, ALU_SLT};
      default: res = {1'b0, ALU_ADD};
    endcase
    return res;
  endfunction

  state_t            state_r;
  state_t            next_state_s;
  logic [ICNT_W-1:0] instret_r;
  logic [3:0]        funct_dec_s;

  logic              mem_req_s;
  logic              ir_we_s;
  logic              pc_we_s;
  logic              reg_we_s;

  assign funct_dec_s = decode_funct(funct);

  // State register; reset parks the sequencer in FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Retired-instruction counter: one count per return to FETCH. HALT never
  // returns to FETCH, so the count freezes there without extra logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_r <= '0;
    end else if ((state_r != ST_FETCH) && (next_state_s == ST_FETCH)) begin
      instret_r <= instret_r + ICNT_W'(1'b1);
    end else begin
      instret_r <= instret_r;
    end
  end

  // Next-state and Moore output decode, all outputs defaulted to 0 first.
  always_comb begin
    next_state_s = state_r;
    mem_req_s    = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_we_s      = 1'b0;
    pc_we_s      = 1'b0;
    pc_src       = 2'd0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'd0;
    alu_op       = ALU_ADD;
    reg_we_s     = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    halted       = 1'b0;

    case (state_r)
      ST_FETCH: begin
        mem_req_s = 1'b1;
        alu_src_b = 2'd1;
        // IR and PC load only in the ack cycle (PC <= PC + 4).
        if (mem_ack) begin
          ir_we_s      = 1'b1;
          pc_we_s      = 1'b1;
          next_state_s = ST_DECODE;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        // Branch target precomputed into ALUOut while decoding.
        alu_src_b = 2'd3;
        case (opcode)
          OP_RTYPE:      next_state_s = ST_EXEC_R;
          OP_ADDI:       next_state_s = ST_EXEC_I;
          OP_LW, OP_SW:  next_state_s = ST_MEM_ADDR;
          OP_BEQ:        next_state_s = ST_BRANCH;
          OP_J:          next_state_s = ST_JUMP;
          default:       next_state_s = ST_HALT;
        endcase
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd0;
        alu_op    = funct_dec_s[2:0];
        // An unknown funct halts here, before any register write.
        if (funct_dec_s[3]) begin
          next_state_s = ST_WB_R;
        end else begin
          next_state_s = ST_HALT;
        end
      end
      ST_WB_R: begin
        reg_we_s     = 1'b1;
        reg_dst      = 1'b1;
        next_state_s = ST_FETCH;
      end
      ST_EXEC_I: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'd2;
        next_state_s = ST_WB_I;
      end
      ST_WB_I: begin
        reg_we_s     = 1'b1;
        next_state_s = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        if (opcode == OP_SW) begin
          next_state_s = ST_MEM_WR;
        end else begin
          next_state_s = ST_MEM_RD;
        end
      end
      ST_MEM_RD: begin
        mem_req_s = 1'b1;
        iord      = 1'b1;
        if (mem_ack) begin
          next_state_s = ST_MEM_WB;
        end else begin
          next_state_s = ST_MEM_RD;
        end
      end
      ST_MEM_WB: begin
        reg_we_s     = 1'b1;
        mem_to_reg   = 1'b1;
        next_state_s = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_req_s = 1'b1;
        mem_we    = 1'b1;
        iord      = 1'b1;
        if (mem_ack) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_MEM_WR;
        end
      end
      ST_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'd0;
        alu_op       = ALU_SUB;
        pc_src       = 2'd1;
        pc_we_s      = zero;
        next_state_s = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src       = 2'd2;
        pc_we_s      = 1'b1;
        next_state_s = ST_FETCH;
      end
      ST_HALT: begin
        halted       = 1'b1;
        next_state_s = ST_HALT;
      end
      default: begin
        // Unreachable codes 12-14 are treated as HALT.
        halted       = 1'b1;
        next_state_s = ST_HALT;
      end
    endcase
  end

  // Reset kills the request and every write enable in the same time step,
  // so an access aborted mid-wait cannot commit anything.
  assign mem_req = mem_req_s & ~rst;
  assign ir_we   = ir_we_s   & ~rst;
  assign pc_we   = pc_we_s   & ~rst;
  assign reg_we  = reg_we_s  & ~rst;
  assign state   = state_r;
  assign instret = instret_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl - self-checking bench for mc_ctrl.
//
// Each test pushes per-cycle expectations (stimulus, output vector,
// retired count) into a queue, then drives one cycle per entry and
// compares the DUT against the popped entry. A second instance with
// ICNT_W=4 checks instret wrap.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst4;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ack;

  logic        mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic        reg_we, reg_dst, mem_to_reg;
  logic [3:0]  state;
  logic        halted;
  logic [31:0] instret;

  logic        mem_req4, mem_we4, iord4, ir_we4, pc_we4;
  logic [1:0]  pc_src4;
  logic        alu_src_a4;
  logic [1:0]  alu_src_b4;
  logic [2:0]  alu_op4;
  logic        reg_we4, reg_dst4, mem_to_reg4;
  logic [3:0]  state4;
  logic        halted4;
  logic [3:0]  instret4;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
    .halted(halted), .instret(instret)
  );

  mc_ctrl #(.ICNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req4), .mem_we(mem_we4), .iord(iord4),
    .ir_we(ir_we4), .pc_we(pc_we4), .pc_src(pc_src4), .alu_src_a(alu_src_a4),
    .alu_src_b(alu_src_b4), .alu_op(alu_op4), .reg_we(reg_we4),
    .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4), .state(state4),
    .halted(halted4), .instret(instret4)
  );

  // Observed output vector: state, mem_req, mem_we, iord, ir_we, pc_we,
  // pc_src, alu_src_a, alu_src_b, alu_op, reg_we, reg_dst, mem_to_reg, halted
  logic [20:0] obs;
  assign obs = {state, mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a,
                alu_src_b, alu_op, reg_we, reg_dst, mem_to_reg, halted};

  typedef struct {
    logic        ack;
    logic        z;
    logic [20:0] exp;
    logic [31:0] icnt;
    logic [3:0]  icnt4;
  } step_t;

  step_t       sq[$];
  step_t       s;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_icnt = 32'd0;
  logic [3:0]  exp_icnt4 = 4'd0;
  logic [3:0]  prev_st = 4'd0;
  logic        run4 = 1'b0;

  // Reference output table for one state.
  function automatic logic [20:0] exp_out(input logic [3:0] st, input logic ack,
                                          input logic z, input logic [2:0] op);
    logic mreq, mwe, io, irw, pcw, sa, rw, rd, m2r, h;
    logic [1:0] ps, sb;
    logic [2:0] ao;
    {mreq, mwe, io, irw, pcw, sa, rw, rd, m2r, h} = 10'd0;
    ps = 2'd0; sb = 2'd0; ao = 3'd0;
    case (st)
      4'd0:  begin mreq = 1'b1; sb = 2'd1; irw = ack; pcw = ack; end
      4'd1:  sb = 2'd3;
      4'd2:  begin sa = 1'b1; ao = op; end
      4'd3:  begin rw = 1'b1; rd = 1'b1; end
      4'd4:  begin sa = 1'b1; sb = 2'd2; end
      4'd5:  rw = 1'b1;
      4'd6:  begin sa = 1'b1; sb = 2'd2; end
      4'd7:  begin mreq = 1'b1; io = 1'b1; end
      4'd8:  begin rw = 1'b1; m2r = 1'b1; end
      4'd9:  begin mreq = 1'b1; mwe = 1'b1; io = 1'b1; end
      4'd10: begin sa = 1'b1; ao = 3'd1; ps = 2'd1; pcw = z; end
      4'd11: begin ps = 2'd2; pcw = 1'b1; end
      default: h = 1'b1;
    endcase
    return {st, mreq, mwe, io, irw, pcw, ps, sa, sb, ao, rw, rd, m2r, h};
  endfunction

  // Queue one cycle of stimulus with its expected outputs and counts.
  task automatic push(input logic [3:0] st, input logic ack, input logic z,
                      input logic [2:0] op);
    step_t e;
    if (st == 4'd0 && prev_st != 4'd0) begin
      exp_icnt = exp_icnt + 32'd1;
      if (run4) exp_icnt4 = exp_icnt4 + 4'd1;
    end
    prev_st = st;
    e.ack = ack; e.z = z; e.exp = exp_out(st, ack, z, op);
    e.icnt = exp_icnt; e.icnt4 = exp_icnt4;
    sq.push_back(e);
  endtask

  task automatic test_reset;
    rst = 1'b1; rst4 = 1'b1; mem_ack = 1'b1; zero = 1'b0;
    opcode = 6'h00; funct = 6'h20;
    @(negedge clk); @(negedge clk); #1;
    n_tests++;
    if (obs !== {4'd0, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd1, 3'd0, 4'b0000}) begin
      n_fail++; $display("FAIL reset outputs: got %h expected %h", obs,
                         {4'd0, 1'b0, 4'b0000, 2'd0, 1'b0, 2'd1, 3'd0, 4'b0000});
    end
    n_tests++;
    if (instret !== 32'd0) begin
      n_fail++; $display("FAIL reset instret: got %0d expected 0", instret);
    end
    mem_ack = 1'b0; rst = 1'b0;
    exp_icnt = 32'd0; prev_st = 4'd0;
    #1;
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL reset first mem_req: got %b expected 1", mem_req);
    end
  endtask

  task automatic test_r_type;
    logic [5:0] fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int i = 0; i < 5; i++) begin
      opcode = 6'h00; funct = fn[i];
      push(4'd0, 1'b1, 1'b0, 3'd0);
      push(4'd1, 1'b0, 1'b0, 3'd0);
      push(4'd2, 1'b0, 1'b0, 3'(i));
      push(4'd3, 1'b0, 1'b0, 3'd0);
      push(4'd0, 1'b0, 1'b0, 3'd0);
      while (sq.size() > 0) begin
        s = sq.pop_front();
        @(negedge clk); mem_ack = s.ack; zero = s.z; #1;
        n_tests++;
        if (obs !== s.exp) begin
          n_fail++; $display("FAIL r_type funct %h: got %h expected %h", fn[i], obs, s.exp);
        end
        n_tests++;
        if (instret !== s.icnt) begin
          n_fail++; $display("FAIL r_type instret: got %0d expected %0d", instret, s.icnt);
        end
      end
    end
    // addi
    opcode = 6'h08;
    push(4'd0, 1'b1, 1'b0, 3'd0);
    push(4'd1, 1'b0, 1'b0, 3'd0);
    push(4'd4, 1'b1, 1'b0, 3'd0);
    push(4'd5, 1'b0, 1'b0, 3'd0);
    push(4'd0, 1'b0, 1'b0, 3'd0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(negedge clk); mem_ack = s.ack; zero = s.z; #1;
      n_tests++;
      if (obs !== s.exp) begin
        n_fail++; $display("FAIL addi: got %h expected %h", obs, s.exp);
      end
      n_tests++;
      if (instret !== s.icnt) begin
        n_fail++; $display("FAIL addi instret: got %0d expected %0d", instret, s.icnt);
      end
    end
  endtask

  task automatic test_mem;
    // lw with three wait cycles in MEM_RD: 8 cycles total.
    opcode = 6'h23;
    push(4'd0, 1'b1, 1'b0, 3'd0);
    push(4'd1, 1'b0, 1'b0, 3'd0);
    push(4'd6, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) push(4'd7, 1'b0, 1'b0, 3'd0);
    push(4'd7, 1'b1, 1'b0, 3'd0);
    push(4'd8, 1'b0, 1'b0, 3'd0);
    push(4'd0, 1'b0, 1'b0, 3'd0);
    // sw with one fetch wait and one write wait.
    push(4'd0, 1'b1, 1'b0, 3'd0);
    push(4'd1, 1'b0, 1'b0, 3'd0);
    push(4'd6, 1'b0, 1'b0, 3'd0);
    push(4'd9, 1'b0, 1'b0, 3'd0);
    push(4'd9, 1'b1, 1'b0, 3'd0);
    push(4'd0, 1'b0, 1'b0, 3'd0);
    push(4'd0, 1'b0, 1'b0, 3'd0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      // Switch to sw once the lw has retired (queue holds only sw steps).
      if (sq.size() == 6) opcode = 6'h2B;
      else opcode = opcode;
      @(negedge clk); mem_ack = s.ack; zero = s.z; #1;
      n_tests++;
      if (obs !== s.exp) begin
        n_fail++; $display("FAIL mem op %h: got %h expected %h", opcode, obs, s.exp);
      end
      n_tests++;
      if (instret !== s.icnt) begin
        n_fail++; $display("FAIL mem instret: got %0d expected %0d", instret, s.icnt);
      end
    end
  endtask

  task automatic test_branch_jump;
    // beq taken then not taken; ack is driven high in non-memory states.
    opcode = 6'h04;
    for (int i = 0; i < 2; i++) begin
      push(4'd0, 1'b1, 1'b0, 3'd0);
      push(4'd1, 1'b1, 1'b0, 3'd0);
      push(4'd10, 1'b1, (i == 0) ? 1'b1 : 1'b0, 3'd0);
    end
    push(4'd0, 1'b0, 1'b0, 3'd0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(negedge clk); mem_ack = s.ack; zero = s.z; #1;
      n_tests++;
      if (obs !== s.exp) begin
        n_fail++; $display("FAIL beq: got %h expected %h", obs, s.exp);
      end
      n_tests++;
      if (instret !== s.icnt) begin
        n_fail++; $display("FAIL beq instret: got %0d expected %0d", instret, s.icnt);
      end
    end
  endtask

  task automatic test_back_to_back;
    // Release the 4-bit instance in lockstep, then retire 16 jumps.
    @(negedge clk); rst4 = 1'b0; run4 = 1'b1; exp_icnt4 = 4'd0;
    opcode = 6'h02;
    for (int i = 0; i < 16; i++) begin
      push(4'd0, 1'b1, 1'b0, 3'd0);
      push(4'd1, 1'b1, 1'b0, 3'd0);
      push(4'd11, 1'b1, 1'b0, 3'd0);
    end
    push(4'd0, 1'b0, 1'b0, 3'd0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(negedge clk); mem_ack = s.ack; zero = s.z; #1;
      n_tests++;
      if (obs !== s.exp) begin
        n_fail++; $display("FAIL jump: got %h expected %h", obs, s.exp);
      end
      n_tests++;
      if (instret !== s.icnt) begin
        n_fail++; $display("FAIL jump instret: got %0d expected %0d", instret, s.icnt);
      end
      n_tests++;
      if (instret4 !== s.icnt4) begin
        n_fail++; $display("FAIL wrap instret4: got %0d expected %0d", instret4, s.icnt4);
      end
    end
    run4 = 1'b0;
  endtask

  task automatic test_halt;
    // Illegal opcode, then illegal funct after a reset pulse.
    for (int k = 0; k < 2; k++) begin
      opcode = (k == 0) ? 6'h3F : 6'h00;
      funct  = 6'h00;
      push(4'd0, 1'b1, 1'b0, 3'd0);
      push(4'd1, 1'b0, 1'b0, 3'd0);
      if (k == 1) push(4'd2, 1'b0, 1'b0, 3'd0);
      push(4'd15, 1'b1, 1'b0, 3'd0);
      push(4'd15, 1'b1, 1'b0, 3'd0);
      push(4'd15, 1'b0, 1'b0, 3'd0);
      while (sq.size() > 0) begin
        s = sq.pop_front();
        @(negedge clk); mem_ack = s.ack; zero = s.z; #1;
        n_tests++;
        if (obs !== s.exp) begin
          n_fail++; $display("FAIL halt case %0d: got %h expected %h", k, obs, s.exp);
        end
        n_tests++;
        if (instret !== s.icnt) begin
          n_fail++; $display("FAIL halt instret: got %0d expected %0d", instret, s.icnt);
        end
      end
      @(negedge clk); rst = 1'b1; #1;
      n_tests++;
      if (state !== 4'd0 || halted !== 1'b0 || instret !== 32'd0) begin
        n_fail++; $display("FAIL halt exit: got state %0d halted %b instret %0d expected 0 0 0",
                           state, halted, instret);
      end
      @(negedge clk); rst = 1'b0;
      exp_icnt = 32'd0; prev_st = 4'd0;
    end
  endtask

  task automatic test_rst_abort;
    opcode = 6'h00; funct = 6'h20;
    push(4'd0, 1'b0, 1'b0, 3'd0);
    push(4'd0, 1'b0, 1'b0, 3'd0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      @(negedge clk); mem_ack = s.ack; zero = s.z; #1;
      n_tests++;
      if (obs !== s.exp) begin
        n_fail++; $display("FAIL abort wait: got %h expected %h", obs, s.exp);
      end
    end
    // Raise rst together with an ack mid-wait: nothing may commit.
    rst = 1'b1; mem_ack = 1'b1; #1;
    n_tests++;
    if ({mem_req, ir_we, pc_we, reg_we} !== 4'b0000) begin
      n_fail++; $display("FAIL abort gating: got req/ir/pc/reg %b expected 0000",
                         {mem_req, ir_we, pc_we, reg_we});
    end
    @(negedge clk); #1;
    n_tests++;
    if (state !== 4'd0 || instret !== 32'd0) begin
      n_fail++; $display("FAIL abort state: got %0d/%0d expected 0/0", state, instret);
    end
    mem_ack = 1'b0; rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_r_type;
    test_mem;
    test_branch_jump;
    test_back_to_back;
    test_halt;
    test_rst_abort;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
